ahb2apb_bridge: RTL



---
 rtl/ahb2apb_pkg.sv | 20 ++
 rtl/ahbif.sv | 33 +++
 rtl/apbif.sv | 26 ++
 rtl/ahb2apb_bridge.sv | 87 ++++++++
 4 files changed

// File: rtl/ahb2apb_pkg.sv
// Shared state encoding and transfer-size helpers for the AHB-Lite to APB4 bridge.
package ahb2apb_pkg;

    typedef enum logic [2:0] {IDLE, SETUP, ACCESS, RESP, ERR1, ERR2} br_state_e;

    function automatic logic [3:0] size2strb(logic [2:0] hsize, logic [1:0] a);
        logic [3:0] s;
        case (hsize)
            3'd0:    s = 4'b0001 << a;
            3'd1:    s = 4'b0011 << a;
            default: s = 4'hF;
        endcase
        return s;
    endfunction

    function automatic logic size_illegal(logic [2:0] hsize, logic [1:0] a);
        return (hsize > 3'd2) || ((hsize == 3'd1) && a[0]) || ((hsize == 3'd2) && (a != 2'b00));
    endfunction

endpackage

// File: rtl/ahbif.sv
// AHB-Lite bus bundle; hreadym is the interconnect-muxed ready seen by every slave.
interface ahbif #(
    parameter int AW = 32
);
    logic          hsel;
    logic [AW-1:0] haddr;
    logic [1:0]    htrans;
    logic          hwrite;
    logic [2:0]    hsize;
    logic [3:0]    hprot;
    logic [31:0]   hwdata;
    logic          hreadym;
    logic          hauser;
    logic          hwuser;
    logic [3:0]    hmaster;
    logic          hmasterlock;
    logic          hready;
    logic          hresp;
    logic [31:0]   hrdata;
    logic          hruser;

    modport slave (
        input  hsel, haddr, htrans, hwrite, hsize, hprot, hwdata, hreadym,
               hauser, hwuser, hmaster, hmasterlock,
        output hready, hresp, hrdata, hruser
    );

    modport master (
        output hsel, haddr, htrans, hwrite, hsize, hprot, hwdata,
               hauser, hwuser, hmaster, hmasterlock,
        input  hreadym, hready, hresp, hrdata, hruser
    );
endinterface

// File: rtl/apbif.sv
// APB4 bus bundle plus the apbactive clock-gating hint.
interface apbif #(
    parameter int PAW = 16
);
    logic           psel;
    logic           penable;
    logic           pwrite;
    logic [PAW-1:0] paddr;
    logic [31:0]    pwdata;
    logic [3:0]     pstrb;
    logic [2:0]     pprot;
    logic           apbactive;
    logic [31:0]    prdata;
    logic           pready;
    logic           pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata, pstrb, pprot, apbactive,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata, pstrb, pprot, apbactive,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/ahb2apb_bridge.sv
// Single-slot AHB-Lite to APB4 bridge: each AHB transfer becomes one SETUP/ACCESS pair,
// with the AHB data phase stalled via hready and pslverr mapped to a two-cycle ERROR.
module ahb2apb_bridge
    import ahb2apb_pkg::*;
#(
    parameter int PAW = 16,
    parameter int AW  = 32
) (
    input logic  clk,
    input logic  resetn,
    ahbif.slave  ahbs,
    apbif.master apbm
);

    br_state_e      state, nxt;
    logic           accept, illegal;
    logic           psel_q, penable_q, pwrite_q, active_q, hready_q, hresp_q;
    logic [PAW-1:0] paddr_q;
    logic [3:0]     pstrb_q;
    logic [2:0]     pprot_q;
    logic [31:0]    hrdata_q;
    logic           unused_ok;

    assign accept  = ahbs.hsel & ahbs.hreadym & ahbs.htrans[1] & hready_q;
    assign illegal = size_illegal(ahbs.hsize, ahbs.haddr[1:0]);

    always_comb begin
        nxt = state;
        case (state)
            IDLE, RESP, ERR2: nxt = accept ? (illegal ? ERR1 : SETUP) : IDLE;
            SETUP:            nxt = ACCESS;
            ACCESS:           if (apbm.pready) nxt = apbm.pslverr ? ERR1 : RESP;
            ERR1:             nxt = ERR2;
            default:          nxt = IDLE;
        endcase
    end

    // Status outputs are decoded from the next state so they leave the bridge as flops.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            pwrite_q  <= 1'b0;
            active_q  <= 1'b0;
            hready_q  <= 1'b1;
            hresp_q   <= 1'b0;
            paddr_q   <= '0;
            pstrb_q   <= '0;
            pprot_q   <= '0;
            hrdata_q  <= '0;
        end else begin
            state     <= nxt;
            psel_q    <= (nxt == SETUP) || (nxt == ACCESS);
            penable_q <= (nxt == ACCESS);
            active_q  <= (nxt != IDLE);
            hready_q  <= !((nxt == SETUP) || (nxt == ACCESS) || (nxt == ERR1));
            hresp_q   <= (nxt == ERR1) || (nxt == ERR2);
            if (accept) begin
                paddr_q  <= ahbs.haddr[PAW-1:0];
                pwrite_q <= ahbs.hwrite;
                pstrb_q  <= ahbs.hwrite ? size2strb(ahbs.hsize, ahbs.haddr[1:0]) : 4'h0;
                pprot_q  <= {~ahbs.hprot[0], 1'b0, ahbs.hprot[1]};
            end
            if ((state == ACCESS) && apbm.pready && !pwrite_q)
                hrdata_q <= apbm.prdata;
        end
    end

    assign apbm.psel      = psel_q;
    assign apbm.penable   = penable_q;
    assign apbm.pwrite    = pwrite_q;
    assign apbm.paddr     = paddr_q;
    assign apbm.pstrb     = pstrb_q;
    assign apbm.pprot     = pprot_q;
    assign apbm.apbactive = active_q;
    assign apbm.pwdata    = ahbs.hwdata;

    assign ahbs.hready = hready_q;
    assign ahbs.hresp  = hresp_q;
    assign ahbs.hrdata = hrdata_q;
    assign ahbs.hruser = 1'b0;

    assign unused_ok = ^{ahbs.haddr[AW-1:0], ahbs.hprot, ahbs.htrans[0], ahbs.hauser,
                         ahbs.hwuser, ahbs.hmaster, ahbs.hmasterlock};

endmodule
